request_unit: RTL and testbench

- Sequences memory requests for the single-cycle MIPS datapath; sits directly downstream of the instruction decoder.
- Consumes the decoder's dREN, dWEN and halt outputs plus the memory controller's ihit/dhit.
- Drives instruction/data read and write enables to memory, the PC-advance enable, and the sticky processor halt.
- Ensures exactly one data access per load/store instruction and prevents re-issue while the same instruction word is held.

---
 rtl/request_unit.sv | 175 +++++++++++++++++
 tb/tb_request_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/request_unit.sv
// ---------------------------------------------------------------------------
// request_unit
//
// Memory request sequencer for the single-cycle MIPS datapath. Sits directly
// after the instruction decoder and decides, per instruction word, whether
// the core may commit this cycle (pc_en), must first run one data access,
// or has reached HALT.
//
// State table
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   FETCH     | waiting for ihit; ALU ops commit on the ihit cycle
//   DATA      | one load/store in flight, request held until dhit
//   HALTED    | HALT retired; all requests off, only RST leaves
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   cu_dREN    in   decoder: instruction is a load
//   cu_dWEN    in   decoder: instruction is a store
//   cu_halt    in   decoder: instruction is HALT
//   ihit       in   memory: instruction word valid this cycle
//   dhit       in   memory: data access completed this cycle
//   imemREN    out  instruction fetch request
//   dmemREN    out  data read request (registered)
//   dmemWEN    out  data write request (registered)
//   pc_en      out  commit enable for the current instruction
//   halt       out  sticky processor halt (registered)
//   instr_cnt  out  retired instruction count
//   stall_cnt  out  cycles spent waiting on memory
//
// Build option
//   REQUEST_UNIT_PERF_EN  when defined, instr_cnt/stall_cnt are saturating
//                         counters; otherwise they are tied to zero and no
//                         counter flops exist.
// ---------------------------------------------------------------------------
module request_unit #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cu_dREN,
    input  logic             cu_dWEN,
    input  logic             cu_halt,
    input  logic             ihit,
    input  logic             dhit,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0] state;
    logic       dmem_ren_q;
    logic       dmem_wen_q;
    logic       halt_q;

    logic       in_fetch;
    logic       in_data;
    logic       is_mem_op;
    logic       alu_commit;
    logic       data_commit;

    always_comb begin
        in_fetch    = (state == ST_FETCH);
        in_data     = (state == ST_DATA);
        is_mem_op   = cu_dREN | cu_dWEN;
        // HALT outranks any load/store flags decoded alongside it.
        alu_commit  = in_fetch & ihit & ~cu_halt & ~is_mem_op;
        data_commit = in_data & dhit;
    end

    // Request/commit outputs. Reset masks the combinational ones at once so
    // nothing is fetched or committed while RST is held.
    always_comb begin
        imemREN = ~RST & (in_fetch | in_data);
        pc_en   = ~RST & (alu_commit | data_commit);
        dmemREN = dmem_ren_q;
        dmemWEN = dmem_wen_q;
        halt    = halt_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_FETCH;
            dmem_ren_q <= 1'b0;
            dmem_wen_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (ihit) begin
                        if (cu_halt) begin
                            state  <= ST_HALTED;
                            halt_q <= 1'b1;
                        end else if (is_mem_op) begin
                            // Store wins on an illegal dual decode so the two
                            // data requests can never be high together.
                            state      <= ST_DATA;
                            dmem_wen_q <= cu_dWEN;
                            dmem_ren_q <= cu_dREN & ~cu_dWEN;
                        end
                    end
                end
                ST_DATA: begin
                    // The PC is held, so the same word stays decoded; only
                    // dhit matters here and there is deliberately no timeout.
                    if (dhit) begin
                        state      <= ST_FETCH;
                        dmem_ren_q <= 1'b0;
                        dmem_wen_q <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    halt_q <= 1'b1;
                end
                default: begin
                    state      <= ST_FETCH;
                    dmem_ren_q <= 1'b0;
                    dmem_wen_q <= 1'b0;
                    halt_q     <= 1'b0;
                end
            endcase
        end
    end

`ifdef REQUEST_UNIT_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] instr_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             count_active;

    // The HALT-detect cycle is still counted as a stall; counting stops once
    // the HALTED state is entered.
    always_comb begin
        count_active = ~RST & (state != ST_HALTED);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (count_active) begin
            if (pc_en) begin
                if (instr_cnt_q != CNT_MAX) begin
                    instr_cnt_q <= instr_cnt_q + 1'b1;
                end
            end else begin
                if (stall_cnt_q != CNT_MAX) begin
                    stall_cnt_q <= stall_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        instr_cnt = instr_cnt_q;
        stall_cnt = stall_cnt_q;
    end
`else
    always_comb begin
        instr_cnt = '0;
        stall_cnt = '0;
    end
`endif

endmodule

// File: tb/tb_request_unit.sv
// Testbench for request_unit: directed scenarios followed by random traffic,
// checked against a transaction-level model through an expectation queue.
module tb_request_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             cu_dREN = 1'b0;
    logic             cu_dWEN = 1'b0;
    logic             cu_halt = 1'b0;
    logic             ihit = 1'b0;
    logic             dhit = 1'b0;
    logic             imemREN;
    logic             dmemREN;
    logic             dmemWEN;
    logic             pc_en;
    logic             halt;
    logic [CNT_W-1:0] instr_cnt;
    logic [CNT_W-1:0] stall_cnt;

    request_unit #(.CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cu_dREN   (cu_dREN),
        .cu_dWEN   (cu_dWEN),
        .cu_halt   (cu_halt),
        .ihit      (ihit),
        .dhit      (dhit),
        .imemREN   (imemREN),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .pc_en     (pc_en),
        .halt      (halt),
        .instr_cnt (instr_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic imem;
        logic dren;
        logic dwen;
        logic pc;
        logic hlt;
        int   icnt;
        int   scnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: the unit is "halted", "busy with one pending access
    // of a given kind", or neither. Counters are plain saturating integers.
    bit m_halted  = 1'b0;
    int m_pending = 0;    // 0 none, 1 load, 2 store
    int m_icnt    = 0;
    int m_scnt    = 0;

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic apply(input logic rst, input logic ih, input logic dh,
                         input logic r, input logic w, input logic h);
        exp_t e;
        bit   commit;
        @(posedge CLK);
        #1;
        RST = rst; ihit = ih; dhit = dh; cu_dREN = r; cu_dWEN = w; cu_halt = h;

        e.dren = (m_pending == 1);
        e.dwen = (m_pending == 2);
        e.hlt  = m_halted;
`ifdef REQUEST_UNIT_PERF_EN
        e.icnt = m_icnt;
        e.scnt = m_scnt;
`else
        e.icnt = 0;
        e.scnt = 0;
`endif
        commit = 1'b0;
        if (rst) begin
            e.imem = 1'b0;
            e.pc   = 1'b0;
            m_pending = 0; m_halted = 1'b0; m_icnt = 0; m_scnt = 0;
        end else if (m_halted) begin
            e.imem = 1'b0;
            e.pc   = 1'b0;
        end else begin
            e.imem = 1'b1;
            if (m_pending != 0) begin
                commit = dh;
                if (dh) m_pending = 0;
            end else if (ih) begin
                if (h)           m_halted = 1'b1;
                else if (w)      m_pending = 2;
                else if (r)      m_pending = 1;
                else             commit = 1'b1;
            end
            e.pc = commit;
            if (commit) m_icnt = sat_inc(m_icnt);
            else        m_scnt = sat_inc(m_scnt);
        end
        exp_q.push_back(e);
    endtask

    // Monitor: one observation per cycle, taken mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (imemREN !== e.imem || dmemREN !== e.dren || dmemWEN !== e.dwen ||
                    pc_en !== e.pc || halt !== e.hlt ||
                    int'(instr_cnt) != e.icnt || int'(stall_cnt) != e.scnt) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got imem=%b dren=%b dwen=%b pc_en=%b halt=%b icnt=%0d scnt=%0d, want imem=%b dren=%b dwen=%b pc_en=%b halt=%b icnt=%0d scnt=%0d",
                             $time, imemREN, dmemREN, dmemWEN, pc_en, halt, instr_cnt, stall_cnt,
                             e.imem, e.dren, e.dwen, e.pc, e.hlt, e.icnt, e.scnt);
                end
            end
        end
    end

    initial begin
        logic r_rst, r_ih, r_dh, r_r, r_w, r_h;

        // Reset for 3 cycles, then four back-to-back ALU instructions.
        repeat (3) apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load with a three-cycle data wait.
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Illegal dual decode: store must win.
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // dhit in FETCH is ignored.
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // HALT with a store flag: no data request, sticky for 20 cycles.
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (20) apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset one cycle into a load.
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Counter saturation with 20 ALU instructions.
        repeat (20) apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            r_rst = ($urandom_range(99) < 2);
            r_ih  = ($urandom_range(99) < 70);
            r_dh  = ($urandom_range(99) < 40);
            r_r   = ($urandom_range(99) < 30);
            r_w   = ($urandom_range(99) < 25);
            r_h   = ($urandom_range(99) < 3);
            apply(r_rst, r_ih, r_dh, r_r, r_w, r_h);
        end

        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
